// File: rtl/demx_pkg.sv
// Shared definitions for the demx_seq8 sequencer slice.
//   NUM_CH       : number of demux output channels (only 8 supported)
//   SEL_W        : channel select width, clog2(NUM_CH)
//   demx_state_t : sequencer FSM states
//   demx_sel_t   : channel select / slot index
//   demx_mask_t  : per-channel enable mask
package demx_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } demx_state_t;

    typedef logic [SEL_W-1:0]  demx_sel_t;
    typedef logic [NUM_CH-1:0] demx_mask_t;

endpackage

// File: rtl/demx_seq8_next_slot.sv
// demx_next_slot: combinational channel scanner for demx_seq8.
//   mask       in  8 : enabled channels
//   cur        in  3 : current slot
//   next_slot  out 3 : lowest enabled channel strictly above cur (cur if none)
//   first_slot out 3 : lowest enabled channel (0 if mask is empty)
//   is_last    out 1 : no enabled channel above cur
module demx_next_slot
    import demx_pkg::*;
(
    input  logic [7:0] mask,
    input  logic [2:0] cur,
    output logic [2:0] next_slot,
    output logic [2:0] first_slot,
    output logic       is_last
);

    // Scan from the top down so the last hit written is the lowest match.
    always_comb begin
        demx_sel_t idx;
        next_slot  = cur;
        first_slot = '0;
        is_last    = 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = demx_sel_t'(NUM_CH - 1 - i);
            if (mask[idx]) begin
                first_slot = idx;
                if (idx > cur) begin
                    next_slot = idx;
                    is_last   = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/demx_seq8.sv
// demx_seq8: upstream sequencer for a 1:8 bit demultiplexer.
// Accepts serial bits over valid/ready and emits one registered (k, s) pair
// per accepted beat, walking enabled channels in ascending order per frame.
//   clk, rst_n        : clock, synchronous active-low reset
//   start, cont       : begin a frame / continuous mode (sampled in IDLE)
//   abort             : terminate current frame
//   chan_en [7:0]     : channel enable mask (used only with DEMX_SEQ_SKIP_EN)
//   din, din_valid    : serial data beat
//   din_ready         : beat accepted this cycle (combinational)
//   k, s [2:0]        : data bit and channel select to the demux
//   k_valid           : k/s carry a fresh beat
//   frame_done        : one-cycle end-of-frame pulse
//   busy              : high in RUN and DONE
// Configuration macro: DEMX_SEQ_SKIP_EN -- when defined, disabled channels in
// chan_en are skipped; otherwise all 8 channels are always used.
module demx_seq8 #(
    parameter int NUM_CH = demx_pkg::NUM_CH,
    parameter int SEL_W  = demx_pkg::SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cont,
    input  logic              abort,
    input  logic [NUM_CH-1:0] chan_en,
    input  logic              din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              k,
    output logic [SEL_W-1:0]  s,
    output logic              k_valid,
    output logic              frame_done,
    output logic              busy
);

    import demx_pkg::*;

    demx_state_t state;
    demx_state_t state_nxt;
    demx_sel_t   slot;
    demx_sel_t   next_slot;
    demx_sel_t   first_slot;
    logic        is_last;
    demx_mask_t  en_q;
    demx_mask_t  eff_mask;
    demx_mask_t  scan_mask;
    logic        cont_q;
    logic        accept;
    logic        start_ok;

`ifdef DEMX_SEQ_SKIP_EN
    assign eff_mask = chan_en;
`else
    logic unused_chan_en;
    assign eff_mask       = '1;
    assign unused_chan_en = ^chan_en;
`endif

    // In IDLE the scanner looks at the incoming mask so first_slot is ready
    // to load on start; afterwards it works on the latched mask.
    assign scan_mask = (state == IDLE) ? eff_mask : en_q;
    assign start_ok  = start && (eff_mask != '0);
    assign accept    = din_valid && din_ready;

    demx_next_slot u_next_slot (
        .mask       (scan_mask),
        .cur        (slot),
        .next_slot  (next_slot),
        .first_slot (first_slot),
        .is_last    (is_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start_ok) state_nxt = RUN;
            RUN: begin
                if (abort)                  state_nxt = IDLE;
                else if (accept && is_last) state_nxt = DONE;
            end
            DONE: state_nxt = (cont_q && !abort) ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        din_ready  = (state == RUN) && !abort;
        busy       = (state != IDLE);
        frame_done = (state == DONE);
    end

    // Slot walker, latched configuration and registered demux outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot    <= '0;
            en_q    <= '0;
            cont_q  <= 1'b0;
            k       <= 1'b0;
            s       <= '0;
            k_valid <= 1'b0;
        end else begin
            k_valid <= accept;
            k       <= accept && din;
            if (accept) s <= slot;
            unique case (state)
                IDLE: if (start_ok) begin
                    en_q   <= eff_mask;
                    cont_q <= cont;
                    slot   <= first_slot;
                end
                RUN:  if (accept && !is_last) slot <= next_slot;
                DONE: if (cont_q && !abort) slot <= first_slot;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_demx_seq8.sv
module tb_demx_seq8;

    logic       clk = 1'b0;
    logic       rst_n, start, cont, abort, din, din_valid;
    logic [7:0] chan_en;
    logic       din_ready, k, k_valid, frame_done, busy;
    logic [2:0] s;

    int n_chk  = 0;
    int n_fail = 0;
    bit checking = 0;

    demx_seq8 #(.NUM_CH(8), .SEL_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
        .chan_en(chan_en), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .k(k), .s(s), .k_valid(k_valid),
        .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Phase: 0 idle, 1 streaming a frame, 2 end-of-frame bubble.
    int       m_phase = 0;
    int       m_frame[$];   // enabled channels of the active frame, ascending
    int       m_pend[$];    // channels still to be filled in this frame
    bit       m_cont = 0;
    bit       exp_kv = 0, exp_k = 0;
    int       exp_s = 0;
    logic [3:0] sb[$];      // {k, s} expected beats

    function automatic logic [7:0] eff(input logic [7:0] m);
`ifdef DEMX_SEQ_SKIP_EN
        return m;
`else
        return 8'hFF;
`endif
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_phase = 0; m_pend.delete(); m_cont = 0;
            exp_kv = 0; exp_k = 0; exp_s = 0;
        end else begin
            exp_kv = 0; exp_k = 0;
            case (m_phase)
                0: if (start && eff(chan_en) != 8'h00) begin
                    logic [7:0] em;
                    em = eff(chan_en);
                    m_frame.delete();
                    for (int c = 0; c < 8; c++) if (em[c]) m_frame.push_back(c);
                    m_pend = m_frame;
                    m_cont = cont;
                    m_phase = 1;
                end
                1: if (abort) m_phase = 0;
                   else if (din_valid) begin
                       int ch;
                       ch = m_pend.pop_front();
                       sb.push_back({din, 3'(ch)});
                       exp_kv = 1; exp_k = din; exp_s = ch;
                       if (m_pend.size() == 0) m_phase = 2;
                   end
                default: begin
                    if (m_cont && !abort) begin
                        m_pend = m_frame;
                        m_phase = 1;
                    end else m_phase = 0;
                end
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (checking) begin
            chk("din_ready", din_ready, (m_phase == 1) && !abort);
            chk("busy", busy, m_phase != 0);
            chk("frame_done", frame_done, m_phase == 2);
            chk("k_valid", k_valid, exp_kv);
            if (k_valid === 1'b1) begin
                if (sb.size() == 0) chk("beat_unexpected", 1, 0);
                else begin
                    logic [3:0] e;
                    e = sb.pop_front();
                    chk("k", k, e[3]);
                    chk("s", s, e[2:0]);
                end
            end else begin
                chk("k_idle", k, 0);
                chk("s_hold", s, exp_s);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_in();
        start = 0; cont = 0; abort = 0; din = 0; din_valid = 0;
    endtask

    task automatic kick(input logic [7:0] m, input bit c);
        start = 1; chan_en = m; cont = c;
        cyc();
        start = 0; cont = 0;
    endtask

    initial begin
        logic [7:0] bits;
        rst_n = 0; chan_en = 8'h00; idle_in();
        cyc(2);
        checking = 1;
        rst_n = 1;
        cyc();

        // Full frame with a fixed bit pattern
        bits = 8'b0100_1101;  // LSB first: 1,0,1,1,0,0,1,0
        kick(8'hFF, 0);
        for (int i = 0; i < 8; i++) begin
            din_valid = 1; din = bits[i];
            cyc();
        end
        idle_in();
        cyc(3);

`ifdef DEMX_SEQ_SKIP_EN
        kick(8'b1010_0100, 0);
        for (int i = 0; i < 4; i++) begin
            din_valid = 1; din = i[0];
            cyc();
        end
        idle_in();
        cyc(2);
        kick(8'h00, 0);
        cyc(3);
`endif

        // Continuous mode, valid held high
        kick(8'hFF, 1);
        for (int i = 0; i < 20; i++) begin
            din_valid = 1; din = 1'($urandom);
            cyc();
        end
        din_valid = 0; abort = 1;
        cyc();
        idle_in();
        cyc(2);

        // Abort colliding with a valid beat at slot 3
        kick(8'hFF, 0);
        for (int i = 0; i < 3; i++) begin
            din_valid = 1; din = 1;
            cyc();
        end
        abort = 1; din_valid = 1; din = 1;
        cyc();
        idle_in();
        cyc(3);

        // Reset mid-frame, then a fresh frame
        kick(8'hFF, 1);
        for (int i = 0; i < 3; i++) begin
            din_valid = 1; din = 1;
            cyc();
        end
        rst_n = 0;
        cyc();
        rst_n = 1; din_valid = 0;
        cyc();
        kick(8'hFF, 0);
        for (int i = 0; i < 8; i++) begin
            din_valid = 1; din = 1'($urandom);
            cyc();
        end
        idle_in();
        cyc(2);

        // Gapped valid, one cycle in three
        kick(8'hFF, 0);
        for (int i = 0; i < 27; i++) begin
            din_valid = (i % 3 == 0); din = 1'($urandom);
            cyc();
        end
        idle_in();
        cyc(2);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            start     = ($urandom_range(0, 9) == 0);
            cont      = 1'($urandom);
            chan_en   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            din       = 1'($urandom);
            din_valid = ($urandom_range(0, 9) < 7);
            abort     = ($urandom_range(0, 19) == 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            cyc();
        end
        rst_n = 1; idle_in();
        cyc(3);

        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/demx_seq8.md
# demx_seq8

Upstream sequencer for the 1:8 bit demultiplexer. Accepts a serial bit stream over a valid/ready handshake and emits one registered (data bit, 3-bit select) pair per accepted beat. The pair walks the enabled output channels in ascending order, one frame per pass. Output `k`/`s` connect directly to the demux data/select inputs; `k_valid` and `frame_done` go to the consuming logic.

## Interface

**Parameters**
- `NUM_CH`, default 8: channel count; only 8 is supported.
- `SEL_W`, default 3: select width; must equal clog2(`NUM_CH`).

**Ports**
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: begin a frame; sampled in IDLE only.
- `cont` in 1: continuous mode; sampled together with `start`.
- `abort` in 1: terminate the current frame.
- `chan_en` in 8: channel enable mask; sampled on accepted `start`.
- `din` in 1: serial data bit.
- `din_valid` in 1: `din` is valid.
- `din_ready` out 1: sequencer accepts a beat this cycle.
- `k` out 1: data bit to the demux; forced to 0 when `k_valid`=0.
- `s` out 3: channel select to the demux.
- `k_valid` out 1: `k`/`s` carry a fresh beat; one cycle per beat.
- `frame_done` out 1: one-cycle pulse at the end of a frame.
- `busy` out 1: high in RUN and DONE.

## Operation

- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `start`=1 and effective mask ≠ 0: latch mask into `en_q` and `cont` into `cont_q`; set `slot` = lowest enabled channel; go to RUN.
  - `start`=1 with effective mask = 0: ignored, no pulse.
- **RUN**
  - `din_ready` = (state==RUN) & !`abort`; this is combinational.
  - A beat is accepted when `din_valid` & `din_ready`. Next edge: `k`←`din`, `s`←`slot`, `k_valid`←1.
  - After an accepted beat, `slot` advances to the next enabled channel above it.
  - If `slot` is the highest enabled channel, the beat is the last of the frame; go to DONE.
  - No beat accepted: `k_valid`←0, `k`←0, `s` holds.
- **DONE** (exactly one cycle)
  - `frame_done`=1 and `din_ready`=0.
  - `cont_q`=1: `slot` reloads to the lowest enabled channel; go to RUN.
  - `cont_q`=0: go to IDLE.
- **abort**
  - In RUN: next state IDLE, no `frame_done`, and no beat accepted that cycle. `abort` wins over a simultaneous valid beat.
  - In DONE: `frame_done` still pulses, then go to IDLE regardless of `cont_q`.
  - In IDLE: no effect.
- `chan_en` changes after start have no effect until the next start.
- `start` while busy is ignored.
- **Reset values:** `k`=0, `s`=0, `k_valid`=0, `frame_done`=0, `busy`=0, `din_ready`=0, state IDLE, `slot`=0, `en_q`=0, `cont_q`=0.
- Reset asserted mid-frame: all of the above take effect at the next edge; partial frame discarded.

## Timing

- Accept-to-output latency: 1 cycle (`k`/`s`/`k_valid` registered).
- Throughput: 1 beat/cycle within a frame.
- One bubble cycle (DONE) between frames in continuous mode.
- `start` → first possible accept: 1 cycle (RUN entered on the edge after `start`).
- Last beat accepted at edge N: `k_valid` and DONE both at N+1; `frame_done` high during cycle N+1.
- Single enabled channel: every frame is one beat; `s` is constant.
- Slot wrap: 7 → lowest enabled channel happens only through DONE, never mid-frame.

## Configuration

- Macro `DEMX_SEQ_SKIP_EN`.
  - **Defined:** the effective mask is `chan_en`; disabled channels are skipped.
  - **Undefined:** the effective mask is 8'hFF and `chan_en` is ignored. Every frame is exactly 8 beats, `s` = 0..7, and `start` is never ignored for a zero mask.

## Structure

- Shared package `demx_pkg`:
  - `NUM_CH`, `SEL_W` constants;
  - `demx_state_t` enum {IDLE, RUN, DONE};
  - `demx_sel_t` (logic [2:0]).
- Sub-module `demx_next_slot` (combinational):
  - inputs mask and current slot;
  - outputs next enabled slot above current, first enabled slot, and an `is_last` flag.
- Top keeps the FSM, handshake and output registers.

## Test plan

- Reset, then `start` with mask FF; stream 8 valid bits 1,0,1,1,0,0,1,0 → `s`=0..7 in order, `k` matches the bits one cycle after each accept, `frame_done` on the cycle after the 8th accept.
- `DEMX_SEQ_SKIP_EN`, mask 8'b1010_0100 → `s` sequence 2,5,7; `frame_done` after the 3rd beat; mask 0 → stays IDLE, `busy`=0.
- `cont`=1 with mask FF, `din_valid` held high for 20 cycles → two full frames with one DONE bubble, `frame_done` twice; `din_ready` low in DONE only.
- `abort` asserted together with `din_valid` at `s`=3 → that beat not accepted, no `frame_done`, IDLE next cycle, `k_valid`=0.
- `rst_n`=0 for one cycle mid-frame → all outputs 0 at the next edge; a new `start` begins again at the lowest enabled slot.
- Gapped `din_valid` (1 cycle in 3) → `k_valid` pulses only after accepts, `k`=0 between beats, `s` holds its last value.
